// File: rtl/apb_cmd_pkg.sv
// Shared types for the APB command master: FSM state encoding, bus widths and
// the response record returned for every accepted command.
package apb_cmd_pkg;

   localparam int APB_ADDR_W = 32;
   localparam int APB_DATA_W = 32;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2,
      RESP   = 2'd3
   } apb_state_t;

   typedef struct packed {
      logic [APB_DATA_W-1:0] rdata;
      logic                  err;
      logic                  timeout;
   } apb_rsp_t;

endpackage

// File: rtl/apb_cmd_master.sv
// Single-outstanding APB3 master: converts a valid/ready command stream into
// SETUP/ACCESS transfers with a wait-state timeout, one response per command.
module apb_cmd_master
   import apb_cmd_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 255,
   parameter int unsigned CNT_W          = 8
) (
   input  logic                  clk,
   input  logic                  rst_,
   input  logic                  req_valid_i,
   output logic                  req_ready_o,
   input  logic                  req_write_i,
   input  logic [APB_ADDR_W-1:0] req_addr_i,
   input  logic [APB_DATA_W-1:0] req_wdata_i,
   output logic                  rsp_valid_o,
   input  logic                  rsp_ready_i,
   output logic [APB_DATA_W-1:0] rsp_rdata_o,
   output logic                  rsp_err_o,
   output logic                  rsp_timeout_o,
   output logic                  m_apb_psel_o,
   output logic                  m_apb_penable_o,
   output logic                  m_apb_pwrite_o,
   output logic [APB_ADDR_W-1:0] m_apb_paddr_o,
   output logic [APB_DATA_W-1:0] m_apb_pwdata_o,
   input  logic                  m_apb_pready_i,
   input  logic [APB_DATA_W-1:0] m_apb_prdata_i,
   input  logic                  m_apb_pslverr_i
);

   localparam int unsigned      TO_LAST_I = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
   localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TO_LAST_I);
   localparam bit               TO_EN     = (TIMEOUT_CYCLES != 0);

   apb_state_t       state, state_nxt;
   apb_rsp_t         rsp_q, rsp_nxt;
   logic [CNT_W-1:0] to_cnt;
   logic             accept;
   logic             aligned;
   logic             to_hit;

   assign accept  = req_valid_i & req_ready_o;
   assign aligned = (req_addr_i[1:0] == 2'b00);
   // pready has priority: the abort only fires on a wait-state cycle
   assign to_hit  = TO_EN && (to_cnt == TO_LAST) && !m_apb_pready_i;

   always_comb begin
      state_nxt = state;
      rsp_nxt   = rsp_q;
      case (state)
         IDLE: begin
            if (accept) begin
               if (aligned) begin
                  state_nxt = SETUP;
               end else begin
                  state_nxt = RESP;
                  rsp_nxt   = '{rdata: '0, err: 1'b1, timeout: 1'b0};
               end
            end
         end
         SETUP: state_nxt = ACCESS;
         ACCESS: begin
            if (m_apb_pready_i) begin
               state_nxt       = RESP;
               rsp_nxt.rdata   = (m_apb_pwrite_o || m_apb_pslverr_i) ? '0 : m_apb_prdata_i;
               rsp_nxt.err     = m_apb_pslverr_i;
               rsp_nxt.timeout = 1'b0;
            end else if (to_hit) begin
               state_nxt = RESP;
               rsp_nxt   = '{rdata: '0, err: 1'b1, timeout: 1'b1};
            end
         end
         RESP: begin
            if (rsp_ready_i) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Outputs are decoded from the next state so every port comes from a flop
   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) begin
         state           <= IDLE;
         rsp_q           <= '0;
         to_cnt          <= '0;
         req_ready_o     <= 1'b0;
         rsp_valid_o     <= 1'b0;
         m_apb_psel_o    <= 1'b0;
         m_apb_penable_o <= 1'b0;
         m_apb_pwrite_o  <= 1'b0;
         m_apb_paddr_o   <= '0;
         m_apb_pwdata_o  <= '0;
      end else begin
         state           <= state_nxt;
         rsp_q           <= rsp_nxt;
         req_ready_o     <= (state_nxt == IDLE);
         rsp_valid_o     <= (state_nxt == RESP);
         m_apb_psel_o    <= (state_nxt == SETUP) || (state_nxt == ACCESS);
         m_apb_penable_o <= (state_nxt == ACCESS);
         if (accept && aligned) begin
            m_apb_pwrite_o <= req_write_i;
            m_apb_paddr_o  <= {req_addr_i[APB_ADDR_W-1:2], 2'b00};
            m_apb_pwdata_o <= req_wdata_i;
         end
         if (state == SETUP) begin
            to_cnt <= '0;
         end else if ((state == ACCESS) && !m_apb_pready_i) begin
            to_cnt <= to_cnt + CNT_W'(1);
         end
      end
   end

   assign rsp_rdata_o   = rsp_q.rdata;
   assign rsp_err_o     = rsp_q.err;
   assign rsp_timeout_o = rsp_q.timeout;

endmodule
